// File: rtl/slc_candidate_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : slc_candidate_tx_pkg                                      |
// | Purpose  : Shared SLC bus constants and slot type for the SLC        |
// |            transmit path (ULT harness / sector-logic emulation).     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package slc_candidate_tx_pkg;

  // Bits per candidate slot on the main-primary SLC port
  localparam int SLC_LEN              = 128;
  // Payload width: slot without its valid flag
  localparam int SLC_RX_LEN           = SLC_LEN - 1;
  // Slots per frame
  localparam int N_PRIMARY_CANDIDATES = 3;
  // Last BCID value before the bunch counter wraps
  localparam int BX_MAX               = 3563;
  // Position of the slot valid flag inside a slot
  localparam int SLC_VALID_BIT        = SLC_LEN - 1;
  // Widths of the BCID and frame counters
  localparam int BCID_W               = 12;
  localparam int FRAME_CNT_W          = 16;

  typedef logic [SLC_LEN-1:0] slc_slot_t;

endpackage
`default_nettype wire

// File: rtl/slc_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : slc_tx_fifo                                               |
// | Purpose  : Circular candidate buffer with N_RD parallel read ports   |
// |            at rd_ptr+k and a bulk pop of 0..N_RD entries per cycle.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module slc_tx_fifo #(
  parameter int WIDTH = 127,
  parameter int DEPTH = 8,
  parameter int N_RD  = 3,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(N_RD + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic [PW-1:0]         pop_n_i,
  output logic [CW-1:0]         count_o,
  output logic [N_RD*WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_n_i);
    count_d  = count_q + CW'(push_i) - CW'(pop_n_i);
  end

  // Pointer and occupancy registers, cleared by the active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (rst && push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;

  generate
    for (genvar k = 0; k < N_RD; k++) begin : g_rd
      assign rd_data_o[k*WIDTH +: WIDTH] = mem_q[rd_ptr_q + AW'(k)];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/slc_candidate_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : slc_candidate_tx                                          |
// | Purpose  : Buffers SLC candidates and packs up to N_CAND of them     |
// |            into one frame per BX strobe, with BCID and status.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module slc_candidate_tx #(
  parameter int SLC_LEN    = slc_candidate_tx_pkg::SLC_LEN,
  parameter int N_CAND     = slc_candidate_tx_pkg::N_PRIMARY_CANDIDATES,
  parameter int FIFO_DEPTH = 8,
  parameter int BX_MAX     = slc_candidate_tx_pkg::BX_MAX
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bx,
  input  logic                      i_bcr,
  input  logic [SLC_LEN-2:0]        i_cand,
  input  logic                      i_cand_valid,
  output logic                      o_cand_ready,
  output logic [N_CAND*SLC_LEN-1:0] o_slc,
  output logic                      o_slc_valid,
  output logic [11:0]               o_bcid,
  output logic                      o_backlog,
  output logic [15:0]               o_frame_cnt
);

  import slc_candidate_tx_pkg::*;

  localparam int PAY_W = SLC_LEN - 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int PW    = $clog2(N_CAND + 1);

  logic [CW-1:0]             w_count;
  logic [N_CAND*PAY_W-1:0]   w_rd_data;
  logic                      w_ready;
  logic                      w_push;
  logic [CW-1:0]             w_n;
  logic [N_CAND*SLC_LEN-1:0] w_frame;

  logic [N_CAND*SLC_LEN-1:0] slc_q,       slc_d;
  logic                      slc_valid_q, slc_valid_d;
  logic                      backlog_q,   backlog_d;
  logic [BCID_W-1:0]         bcid_q,      bcid_d;
  logic [FRAME_CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                      bcr_q,       bcr_d;

  // Handshake and pop amount, all from the pre-push occupancy
  always_comb begin
    w_ready = rst & (w_count < CW'(FIFO_DEPTH));
    w_push  = i_cand_valid & w_ready;
    w_n     = '0;
    if (bx) begin
      w_n = (w_count < CW'(N_CAND)) ? w_count : CW'(N_CAND);
    end
  end

  slc_tx_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (FIFO_DEPTH),
    .N_RD  (N_CAND)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i (i_cand),
    .pop_n_i     (PW'(w_n)),
    .count_o     (w_count),
    .rd_data_o   (w_rd_data)
  );

  // Slot k carries the k-th oldest candidate with its valid flag, else zeros
  generate
    for (genvar k = 0; k < N_CAND; k++) begin : g_slot
      assign w_frame[k*SLC_LEN +: SLC_LEN] = (CW'(k) < w_n) ?
          {1'b1, w_rd_data[k*PAY_W +: PAY_W]} : '0;
    end
  endgenerate

  // Frame, BCID, BCR latch and status next-state; a bx always emits a frame
  always_comb begin
    slc_d       = slc_q;
    slc_valid_d = 1'b0;
    backlog_d   = backlog_q;
    bcid_d      = bcid_q;
    frame_cnt_d = frame_cnt_q;
    bcr_d       = bcr_q | i_bcr;
    if (bx) begin
      slc_d       = w_frame;
      slc_valid_d = 1'b1;
      backlog_d   = (w_count != w_n);
      if (bcr_q || i_bcr) begin
        bcid_d = '0;
      end else if (bcid_q == BCID_W'(BX_MAX)) begin
        bcid_d = '0;
      end else begin
        bcid_d = bcid_q + 1'b1;
      end
      if (w_n != '0) begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
      bcr_d = 1'b0;
    end
  end

  // Output and status registers; reset discards any frame in progress
  always_ff @(posedge clk) begin
    if (!rst) begin
      slc_q       <= '0;
      slc_valid_q <= 1'b0;
      backlog_q   <= 1'b0;
      bcid_q      <= '0;
      frame_cnt_q <= '0;
      bcr_q       <= 1'b0;
    end else begin
      slc_q       <= slc_d;
      slc_valid_q <= slc_valid_d;
      backlog_q   <= backlog_d;
      bcid_q      <= bcid_d;
      frame_cnt_q <= frame_cnt_d;
      bcr_q       <= bcr_d;
    end
  end

  assign o_cand_ready = w_ready;
  assign o_slc        = slc_q;
  assign o_slc_valid  = slc_valid_q;
  assign o_bcid       = bcid_q;
  assign o_backlog    = backlog_q;
  assign o_frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_slc_candidate_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_slc_candidate_tx                                       |
// | Purpose  : Self-checking bench for slc_candidate_tx against a        |
// |            queue-based frame model.                                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_slc_candidate_tx;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         bx = 1'b0;
  logic         bcr = 1'b0;
  logic [126:0] cand = '0;
  logic         cand_valid = 1'b0;
  logic         o_cand_ready;
  logic [383:0] o_slc;
  logic         o_slc_valid;
  logic [11:0]  o_bcid;
  logic         o_backlog;
  logic [15:0]  o_frame_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [126:0] mq[$];
  logic [383:0] m_slc = '0;
  logic         m_valid = 1'b0;
  logic         m_backlog = 1'b0;
  logic [11:0]  m_bcid = '0;
  logic [15:0]  m_fcnt = '0;
  logic         m_bcr = 1'b0;

  always #5 clk = ~clk;

  slc_candidate_tx dut (
    .clk          (clk),
    .rst          (rst),
    .bx           (bx),
    .i_bcr        (bcr),
    .i_cand       (cand),
    .i_cand_valid (cand_valid),
    .o_cand_ready (o_cand_ready),
    .o_slc        (o_slc),
    .o_slc_valid  (o_slc_valid),
    .o_bcid       (o_bcid),
    .o_backlog    (o_backlog),
    .o_frame_cnt  (o_frame_cnt)
  );

  // Advance the model by one clock edge with the current inputs, then the DUT
  task automatic cycle();
    logic [383:0] f;
    int           n;
    bit           push;
    push = 1'b0;
    if (!rst) begin
      mq.delete();
      m_slc = '0; m_valid = 1'b0; m_backlog = 1'b0;
      m_bcid = '0; m_fcnt = '0; m_bcr = 1'b0;
    end else begin
      push = cand_valid && (mq.size() < 8);
      if (bx) begin
        n = (mq.size() < 3) ? mq.size() : 3;
        f = '0;
        for (int k = 0; k < n; k++) f[k*128 +: 128] = {1'b1, mq.pop_front()};
        m_slc     = f;
        m_valid   = 1'b1;
        m_backlog = (mq.size() != 0);
        m_bcid    = (m_bcr || bcr) ? 12'd0 : ((m_bcid == 12'd3563) ? 12'd0 : m_bcid + 12'd1);
        m_bcr     = 1'b0;
        if (n > 0) m_fcnt = m_fcnt + 16'd1;
      end else begin
        m_valid = 1'b0;
        m_bcr   = m_bcr | bcr;
      end
      if (push) mq.push_back(cand);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; bx = 1'b0; bcr = 1'b0; cand_valid = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  task automatic push_one(input logic [126:0] d);
    cand = d; cand_valid = 1'b1;
    cycle();
    cand_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cycle();
    cycle();
    n_vec++; if (o_slc !== '0) begin n_err++; $display("FAIL reset_slc got %h exp 0", o_slc); end
    n_vec++; if (o_slc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", o_slc_valid); end
    n_vec++; if (o_bcid !== 12'd0) begin n_err++; $display("FAIL reset_bcid got %0d exp 0", o_bcid); end
    n_vec++; if (o_backlog !== 1'b0) begin n_err++; $display("FAIL reset_backlog got %b exp 0", o_backlog); end
    n_vec++; if (o_frame_cnt !== 16'd0) begin n_err++; $display("FAIL reset_fcnt got %0d exp 0", o_frame_cnt); end
    n_vec++; if (o_cand_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", o_cand_ready); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [126:0] a, b;
    a = 127'({$urandom(), $urandom(), $urandom(), $urandom()});
    b = 127'({$urandom(), $urandom(), $urandom(), $urandom()});
    do_reset();
    cycle();
    push_one(a);
    push_one(b);
    cycle(); cycle();
    bx = 1'b1; cycle(); bx = 1'b0;
    n_vec++; if (o_slc_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b exp 1", o_slc_valid); end
    n_vec++; if (o_slc !== {128'd0, 1'b1, b, 1'b1, a}) begin n_err++; $display("FAIL basic_slc got %h exp %h", o_slc, {128'd0, 1'b1, b, 1'b1, a}); end
    n_vec++; if (o_backlog !== 1'b0) begin n_err++; $display("FAIL basic_backlog got %b exp 0", o_backlog); end
    n_vec++; if (o_frame_cnt !== 16'd1) begin n_err++; $display("FAIL basic_fcnt got %0d exp 1", o_frame_cnt); end
    cycle();
    n_vec++; if (o_slc_valid !== 1'b0) begin n_err++; $display("FAIL basic_strobe got %b exp 0", o_slc_valid); end
    n_vec++; if (o_slc !== m_slc) begin n_err++; $display("FAIL basic_hold got %h exp %h", o_slc, m_slc); end
  endtask

  task automatic test_split();
    do_reset();
    for (int i = 0; i < 5; i++) push_one(127'({$urandom(), $urandom(), $urandom(), $urandom()}));
    for (int f = 0; f < 2; f++) begin
      bx = 1'b1; cycle(); bx = 1'b0;
      n_vec++; if (o_slc !== m_slc) begin n_err++; $display("FAIL split_slc%0d got %h exp %h", f, o_slc, m_slc); end
      n_vec++; if (o_backlog !== (f == 0)) begin n_err++; $display("FAIL split_backlog%0d got %b exp %b", f, o_backlog, f == 0); end
      n_vec++; if (o_slc[383] !== (f == 0)) begin n_err++; $display("FAIL split_slot2%0d got %b exp %b", f, o_slc[383], f == 0); end
      cycle();
    end
  endtask

  task automatic test_full();
    logic [126:0] x;
    do_reset();
    for (int i = 0; i < 8; i++) push_one(127'({$urandom(), $urandom(), $urandom(), $urandom()}));
    n_vec++; if (o_cand_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b exp 0", o_cand_ready); end
    x = 127'({$urandom(), $urandom(), $urandom(), $urandom()});
    cand = x; cand_valid = 1'b1; bx = 1'b1;
    #1;
    n_vec++; if (o_cand_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_bx got %b exp 0", o_cand_ready); end
    cycle(); bx = 1'b0;
    n_vec++; if (o_cand_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_rise got %b exp 1", o_cand_ready); end
    n_vec++; if (o_slc !== m_slc) begin n_err++; $display("FAIL full_slc0 got %h exp %h", o_slc, m_slc); end
    cycle(); cand_valid = 1'b0;
    bx = 1'b1; cycle(); bx = 1'b0;
    n_vec++; if (o_slc !== m_slc || o_backlog !== 1'b1) begin n_err++; $display("FAIL full_slc1 got %h/%b exp %h/1", o_slc, o_backlog, m_slc); end
    bx = 1'b1; cycle(); bx = 1'b0;
    n_vec++; if (o_slc[256 +: 128] !== {1'b1, x}) begin n_err++; $display("FAIL full_held got %h exp %h", o_slc[256 +: 128], {1'b1, x}); end
    n_vec++; if (o_backlog !== 1'b0) begin n_err++; $display("FAIL full_backlog got %b exp 0", o_backlog); end
  endtask

  task automatic test_back_to_back();
    logic [126:0] c;
    logic [15:0]  fc;
    do_reset();
    fc = o_frame_cnt;
    c = 127'({$urandom(), $urandom(), $urandom(), $urandom()});
    cand = c; cand_valid = 1'b1; bx = 1'b1;
    cycle(); cand_valid = 1'b0;
    n_vec++; if (o_slc !== '0 || o_slc_valid !== 1'b1) begin n_err++; $display("FAIL coinc_empty got %h/%b exp 0/1", o_slc, o_slc_valid); end
    n_vec++; if (o_frame_cnt !== fc) begin n_err++; $display("FAIL coinc_fcnt got %0d exp %0d", o_frame_cnt, fc); end
    cycle(); bx = 1'b0;
    n_vec++; if (o_slc !== {256'd0, 1'b1, c} || o_slc_valid !== 1'b1) begin n_err++; $display("FAIL coinc_next got %h exp %h", o_slc, {256'd0, 1'b1, c}); end
    n_vec++; if (o_frame_cnt !== fc + 16'd1) begin n_err++; $display("FAIL coinc_fcnt2 got %0d exp %0d", o_frame_cnt, fc + 16'd1); end
  endtask

  task automatic test_bcid();
    do_reset();
    for (int i = 1; i <= 3564; i++) begin
      bx = 1'b1; cycle(); bx = 1'b0;
      n_vec++; if (o_bcid !== 12'((i == 3564) ? 0 : i)) begin n_err++; $display("FAIL bcid_run got %0d exp %0d", o_bcid, (i == 3564) ? 0 : i); end
      cycle();
    end
    bx = 1'b1; cycle(); bx = 1'b0;
    bcr = 1'b1; cycle(); bcr = 1'b0;
    cycle();
    bx = 1'b1; cycle(); bx = 1'b0;
    n_vec++; if (o_bcid !== 12'd0) begin n_err++; $display("FAIL bcid_bcr got %0d exp 0", o_bcid); end
    cycle();
    bx = 1'b1; cycle(); bx = 1'b0;
    n_vec++; if (o_bcid !== 12'd1) begin n_err++; $display("FAIL bcid_after got %0d exp 1", o_bcid); end
    bcr = 1'b1; bx = 1'b1; cycle(); bx = 1'b0; bcr = 1'b0;
    n_vec++; if (o_bcid !== 12'd0) begin n_err++; $display("FAIL bcid_coinc got %0d exp 0", o_bcid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bx = 1'b1; cycle(); bx = 1'b0;
    for (int i = 0; i < 4; i++) push_one(127'({$urandom(), $urandom(), $urandom(), $urandom()}));
    rst = 1'b0; cycle();
    n_vec++; if ({o_slc, o_slc_valid, o_bcid, o_backlog, o_frame_cnt} !== '0) begin n_err++; $display("FAIL rstmid_outs got %h/%b/%0d/%b/%0d exp all 0", o_slc, o_slc_valid, o_bcid, o_backlog, o_frame_cnt); end
    n_vec++; if (o_cand_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready_lo got %b exp 0", o_cand_ready); end
    rst = 1'b1; #1;
    n_vec++; if (o_cand_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready_hi got %b exp 1", o_cand_ready); end
    bx = 1'b1; cycle(); bx = 1'b0;
    n_vec++; if (o_slc !== '0 || o_slc_valid !== 1'b1 || o_frame_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_frame got %h/%b/%0d exp 0/1/0", o_slc, o_slc_valid, o_frame_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) != 0);
      bx         = ($urandom_range(0, 3) == 0);
      bcr        = ($urandom_range(0, 49) == 0);
      cand_valid = ($urandom_range(0, 9) < 7);
      cand       = 127'({$urandom(), $urandom(), $urandom(), $urandom()});
      #1;
      n_vec++; if (o_cand_ready !== (rst && mq.size() < 8)) begin n_err++; $display("FAIL rand_ready @%0d got %b exp %b", i, o_cand_ready, rst && mq.size() < 8); end
      cycle();
      n_vec++; if (o_slc !== m_slc || o_slc_valid !== m_valid) begin n_err++; $display("FAIL rand_frame @%0d got %h/%b exp %h/%b", i, o_slc, o_slc_valid, m_slc, m_valid); end
      n_vec++; if (o_bcid !== m_bcid || o_backlog !== m_backlog || o_frame_cnt !== m_fcnt) begin n_err++; $display("FAIL rand_status @%0d got %0d/%b/%0d exp %0d/%b/%0d", i, o_bcid, o_backlog, o_frame_cnt, m_bcid, m_backlog, m_fcnt); end
    end
    rst = 1'b1; bx = 1'b0; bcr = 1'b0; cand_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_full();
    test_back_to_back();
    test_bcid();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
